// File: rtl/mau_pkg.sv
// Shared encodings, FSM state type and alignment helper for the memory access unit.
package mau_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } state_t;

   // The illegal size code is folded in here so callers get a single error flag.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mau_lane.sv
// Little-endian lane logic: extracts and extends sub-word load data, and
// merges sub-word store data into a previously read word.
module mau_lane
   import mau_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        is_unsigned,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        sign_bit;

   always_comb begin
      byte_lane = word[{addr_lo, 3'b000} +: 8];
      half_lane = addr_lo[1] ? word[31:16] : word[15:0];
      sign_bit  = 1'b0;
      load_data = word;
      case (size)
         SZ_BYTE: begin
            sign_bit  = byte_lane[7] & ~is_unsigned;
            load_data = {{24{sign_bit}}, byte_lane};
         end
         SZ_HALF: begin
            sign_bit  = half_lane[15] & ~is_unsigned;
            load_data = {{16{sign_bit}}, half_lane};
         end
         default: load_data = word;
      endcase
   end

   // Only the addressed lane(s) are replaced; the rest of the read word is kept.
   always_comb begin
      merged = word;
      case (size)
         SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: begin
            if (addr_lo[1]) merged[31:16] = wdata[15:0];
            else            merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-only data memory;
// sub-word stores are performed as read-modify-write.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state;
   state_t            state_next;

   logic              wr_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   logic              accept;
   logic              req_err;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merged;

   assign accept  = req_valid && req_ready;
   assign req_err = is_misaligned(req_size, req_addr[1:0]);

   mau_lane u_lane (
      .size        (size_q),
      .addr_lo     (addr_q[1:0]),
      .is_unsigned (unsigned_q),
      .word        (rdata_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
      end else if (accept) begin
         wr_q       <= req_wr;
         size_q     <= req_size;
         unsigned_q <= req_unsigned;
         addr_q     <= req_addr;
         wdata_q    <= req_wdata;
         err_q      <= req_err;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)              rdata_q <= '0;
      else if (state == READ) rdata_q <= mem_rdata;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)                           state_next = RESP;
               else if (req_wr && req_size == SZ_WORD) state_next = WRITE;
               else                                    state_next = READ;
            end
         end
         READ:    state_next = wr_q ? WRITE : RESP;
         WRITE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // mem_wr is gated by reset so an aborted read-modify-write never writes a partial word.
   always_comb begin
      req_ready  = (state == IDLE) && !reset;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
      mem_wdata  = '0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      case (state)
         READ:  mem_rd = 1'b1;
         WRITE: begin
            mem_wr    = !reset;
            mem_wdata = (size_q == SZ_WORD) ? wdata_q : merged;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (err_q || wr_q) ? '0 : load_data;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer between the CPU MEM stage and the word-only data memory. It accepts byte, halfword and word requests with a ready/valid handshake. Sub-word stores become a read-modify-write over the 32-bit word interface. Sub-word loads are extracted and sign- or zero-extended. Misaligned and illegal-size requests are flagged and never reach memory.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width; fixed at 32, lane logic assumes 4 bytes

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
req_valid  in  1  CPU request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_wr  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data; the value occupies the low bits (byte [7:0], half [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal size; valid with resp_valid
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable, written on posedge
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset: state IDLE; resp_valid, resp_err, resp_rdata, mem_rd, mem_wr, mem_wdata = 0. req_ready = 1 from the first cycle after reset deasserts.
- Request capture: a request is accepted when req_valid && req_ready. All req_* fields are latched on acceptance and held until RESP. Inputs outside the accept cycle are ignored.
- State IDLE: on accept, go to:
  - RESP, if the request is an error;
  - WRITE, for a word store;
  - READ, for any load or a sub-word store.
- State READ: mem_rd = 1, mem_addr = latched word address; latch mem_rdata at the clock edge.
  - Load: go to RESP.
  - Sub-word store: go to WRITE.
- State WRITE: mem_wr = 1.
  - Word store: mem_wdata = latched wdata.
  - Sub-word store: mem_wdata = latched read word with the target lane(s) replaced.
  - Then go to RESP.
- State RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- mem_rd and mem_wr are never both high. Both are 0 in IDLE and RESP.
- Lane map (little-endian):
  - byte k = word[8k+7:8k], where k = addr[1:0];
  - half = word[15:0] if addr[1] = 0, else word[31:16].
- Load extension: bit 7 (byte) or bit 15 (half) is replicated when req_unsigned = 0; zeros are used otherwise.
- Error conditions:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11.
- On error: resp_err = 1, resp_rdata = 0, and no mem_rd or mem_wr is ever asserted.
- Latency, with the accept cycle as T and resp_valid asserted in cycle:
  - T+1 for an error;
  - T+2 for a load;
  - T+2 for a word store;
  - T+3 for a sub-word store.
- Back-to-back: the next accept can occur in the cycle after RESP, when req_ready returns high.
- Reset mid-operation: state returns to IDLE on the reset edge. mem_wr is gated with !reset, so no write issues in a reset cycle, and a pending RMW is dropped with no partial write. No resp_valid is produced for the aborted request.
- Out-of-range addresses are passed through unchanged. Range checking belongs to the memory.

Decomposition:
- Package mau_pkg holds:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - the state enum IDLE/READ/WRITE/RESP;
  - the function is_misaligned(size, addr[1:0]).
- Sub-module mau_lane (purely combinational) does two jobs:
  - extract + extend for loads;
  - lane merge for stores.
- The FSM and request registers live in mem_access_unit.

Test Plan:
- Load byte, signed: mem word 0x80FF7F01 at 0x10; lb 0x13 -> resp_rdata 0xFFFFFF80 at T+2; lbu 0x13 -> 0x00000080; lb 0x11 -> 0x0000007F.
- Halfword store RMW: word 0x11223344 at 0x20; sh 0xBEEF to 0x22 -> mem_rd in T+1, mem_wr in T+2 with mem_wdata 0xBEEF3344, resp_valid at T+3; a following lw 0x20 -> 0xBEEF3344.
- Misalignment: lw 0x21, lh 0x23, size 11 -> each gives resp_err = 1 at T+1, resp_rdata 0, mem_rd/mem_wr never high.
- Handshake: req_valid held high for 3 back-to-back words -> req_ready low between accepts; exactly one resp_valid pulse per accept; request fields changed during READ are ignored.
- Reset mid-RMW: assert reset in the READ cycle of sb 0xAA to 0x31 -> no mem_wr; the memory word is unchanged; no resp_valid; req_ready = 1 after release.
- Word store: sw 0xDEADBEEF to 0x40 -> no mem_rd; mem_wr in T+1 with mem_wdata 0xDEADBEEF; resp_valid at T+2.
